// File: rtl/ehl_timer_cpt_filter.sv
// ---------------------------------------------------------------------------
// ehl_timer_cpt_filter
//
// Capture-input conditioner placed in front of the timer's cpt_in pins. Each
// raw capture pin goes through a two-flop synchronizer, then a digital glitch
// filter sampled by a shared prescaled strobe, then a registered edge
// detector.
//
// Parameters
//   NCH        number of independent capture channels
//   FLT_WIDTH  width of each filter-length field and per-channel counter
//   PRE_WIDTH  width of the shared sample-prescaler divider
//
// Ports
//   clk         in   block clock, rising edge
//   reset       in   asynchronous, active-high reset
//   pin_in      in   [NCH]            raw asynchronous capture inputs
//   ena         in   [NCH]            per-channel enable
//   flt_len     in   [NCH*FLT_WIDTH]  per-channel filter length (0 = bypass)
//   pre_div     in   [PRE_WIDTH]      sample strobe period minus one
//   glitch_clr  in   [NCH]            per-channel clear for the glitch flag
//   cpt_out     out  [NCH]            filtered level
//   rise        out  [NCH]            one-cycle pulse on filtered 0->1
//   fall        out  [NCH]            one-cycle pulse on filtered 1->0
//   glitch      out  [NCH]            sticky: a rejected pulse was seen
// ---------------------------------------------------------------------------
module ehl_timer_cpt_filter #(
    parameter int NCH       = 2,
    parameter int FLT_WIDTH = 4,
    parameter int PRE_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           pin_in,
    input  logic [NCH-1:0]           ena,
    input  logic [NCH*FLT_WIDTH-1:0] flt_len,
    input  logic [PRE_WIDTH-1:0]     pre_div,
    input  logic [NCH-1:0]           glitch_clr,
    output logic [NCH-1:0]           cpt_out,
    output logic [NCH-1:0]           rise,
    output logic [NCH-1:0]           fall,
    output logic [NCH-1:0]           glitch
);

    // Synchronizer stages; sync2_q is the synchronized level s.
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;

    // Shared prescaler.
    logic [PRE_WIDTH-1:0] pcnt_q;
    logic [PRE_WIDTH-1:0] pcnt_d;
    logic                 stb;

    // Per-channel filter state and registered outputs.
    logic [NCH-1:0]                lvl_q;
    logic [NCH-1:0]                lvl_d;
    logic [NCH-1:0][FLT_WIDTH-1:0] fcnt_q;
    logic [NCH-1:0][FLT_WIDTH-1:0] fcnt_d;
    logic [NCH-1:0]                glitch_q;
    logic [NCH-1:0]                glitch_d;
    logic [NCH-1:0]                glitch_set;
    logic [NCH-1:0]                rise_q;
    logic [NCH-1:0]                rise_d;
    logic [NCH-1:0]                fall_q;
    logic [NCH-1:0]                fall_d;

    // A >= compare (rather than ==) means lowering pre_div below the running
    // count fires on the next cycle instead of wrapping through 2^PRE_WIDTH.
    assign stb    = (pcnt_q >= pre_div);
    assign pcnt_d = stb ? '0 : pcnt_q + PRE_WIDTH'(1);

    always_comb begin
        lvl_d      = lvl_q;
        fcnt_d     = fcnt_q;
        glitch_set = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!ena[k]) begin
                // Forced clear; the edge detector is gated by ena so no fall.
                lvl_d[k]  = 1'b0;
                fcnt_d[k] = '0;
            end else if (flt_len[k*FLT_WIDTH +: FLT_WIDTH] == '0) begin
                lvl_d[k]  = sync2_q[k];
                fcnt_d[k] = '0;
            end else if (stb) begin
                if (sync2_q[k] == lvl_q[k]) begin
                    // Input fell back before the count completed: a glitch.
                    if (fcnt_q[k] != '0) begin
                        glitch_set[k] = 1'b1;
                    end
                    fcnt_d[k] = '0;
                end else if (({1'b0, fcnt_q[k]} + (FLT_WIDTH+1)'(1)) >=
                             {1'b0, flt_len[k*FLT_WIDTH +: FLT_WIDTH]}) begin
                    // Compared with one extra bit so the counter can never
                    // wrap, even if flt_len is lowered mid-count.
                    lvl_d[k]  = ~lvl_q[k];
                    fcnt_d[k] = '0;
                end else begin
                    fcnt_d[k] = fcnt_q[k] + FLT_WIDTH'(1);
                end
            end
        end
    end

    // Set has priority over a simultaneous clear.
    assign glitch_d = glitch_set | (glitch_q & ~glitch_clr);
    assign rise_d   =  lvl_d & ~lvl_q & ena;
    assign fall_d   = ~lvl_d &  lvl_q & ena;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            pcnt_q   <= '0;
            lvl_q    <= '0;
            fcnt_q   <= '0;
            glitch_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            sync1_q  <= pin_in;
            sync2_q  <= sync1_q;
            pcnt_q   <= pcnt_d;
            lvl_q    <= lvl_d;
            fcnt_q   <= fcnt_d;
            glitch_q <= glitch_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign cpt_out = lvl_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign glitch  = glitch_q;

endmodule

// File: tb/tb_ehl_timer_cpt_filter.sv
module tb_ehl_timer_cpt_filter;

    localparam int NCH = 2;
    localparam int FW  = 4;
    localparam int PW  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    pin_in;
    logic [NCH-1:0]    ena;
    logic [NCH*FW-1:0] flt_len;
    logic [PW-1:0]     pre_div;
    logic [NCH-1:0]    glitch_clr;
    logic [NCH-1:0]    cpt_out;
    logic [NCH-1:0]    rise;
    logic [NCH-1:0]    fall;
    logic [NCH-1:0]    glitch;

    ehl_timer_cpt_filter #(.NCH(NCH), .FLT_WIDTH(FW), .PRE_WIDTH(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pin_in     (pin_in),
        .ena        (ena),
        .flt_len    (flt_len),
        .pre_div    (pre_div),
        .glitch_clr (glitch_clr),
        .cpt_out    (cpt_out),
        .rise       (rise),
        .fall       (fall),
        .glitch     (glitch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: the raw pin delayed two edges, a "cycles since last
    // strobe" counter, and for each channel the number of consecutive strobe
    // samples that disagreed with the accepted level.
    logic [NCH-1:0] m_d1, m_d2;
    int             m_since;
    int             m_run [NCH];
    logic [NCH-1:0] m_lvl, m_rise, m_fall, m_glitch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_since = 0;
        m_lvl = '0; m_rise = '0; m_fall = '0; m_glitch = '0;
        for (int k = 0; k < NCH; k++) m_run[k] = 0;
    endtask

    task automatic model_edge();
        bit             sample;
        int             n;
        logic           old, nl, gs;
        logic [NCH-1:0] s;
        s      = m_d2;
        sample = (m_since >= int'(pre_div));
        m_since = sample ? 0 : m_since + 1;
        for (int k = 0; k < NCH; k++) begin
            n  = int'(flt_len[k*FW +: FW]);
            old = m_lvl[k];
            nl = old;
            gs = 1'b0;
            if (!ena[k]) begin
                nl = 1'b0; m_run[k] = 0;
            end else if (n == 0) begin
                nl = s[k]; m_run[k] = 0;
            end else if (sample) begin
                if (s[k] == old) begin
                    gs = (m_run[k] != 0);
                    m_run[k] = 0;
                end else begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] >= n) begin
                        nl = ~old; m_run[k] = 0;
                    end
                end
            end
            m_glitch[k] = gs | (m_glitch[k] & ~glitch_clr[k]);
            m_rise[k]   = nl & ~old & ena[k];
            m_fall[k]   = ~nl & old & ena[k];
            m_lvl[k]    = nl;
        end
        m_d2 = m_d1;
        m_d1 = pin_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cpt_out", 32'(cpt_out), 32'(m_lvl));
        chk("rise",    32'(rise),    32'(m_rise));
        chk("fall",    32'(fall),    32'(m_fall));
        chk("glitch",  32'(glitch),  32'(m_glitch));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cpt"},    32'(cpt_out), 32'd0);
        chk({tag, "_rise"},   32'(rise),    32'd0);
        chk({tag, "_fall"},   32'(fall),    32'd0);
        chk({tag, "_glitch"}, 32'(glitch),  32'd0);
    endtask

    int nrise, nfall, cnt;
    bit seen_rise, stayed_low, stayed_high;

    initial begin
        // Reset with all pins high: everything must read zero.
        pin_in = '1; ena = '1; flt_len = '0; pre_div = '0; glitch_clr = '0;
        reset = 1'b1;
        #3;
        model_reset();
        chk_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        reset = 1'b0;

        // Bypass: level and rise appear at the 3rd edge.
        step(); chk("byp_e1_cpt", 32'(cpt_out), 32'd0);
        step(); chk("byp_e2_cpt", 32'(cpt_out), 32'd0);
        step(); chk("byp_e3_cpt", 32'(cpt_out), 32'h3);
                chk("byp_e3_rise", 32'(rise), 32'h3);
        step(); chk("byp_e4_rise", 32'(rise), 32'd0);

        // Settle both channels low with N=3.
        pin_in = '0; flt_len = {4'd3, 4'd3};
        repeat (8) step();
        chk("settle_cpt", 32'(cpt_out), 32'd0);

        // Glitch reject: 2-clk pulse with N=3.
        seen_rise = 1'b0; stayed_low = 1'b1;
        pin_in[0] = 1'b1;
        repeat (2) step();
        pin_in[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rise[0]) seen_rise = 1'b1;
            if (cpt_out[0]) stayed_low = 1'b0;
        end
        chk("glrej_no_rise", 32'(seen_rise), 32'd0);
        chk("glrej_cpt_low", 32'(stayed_low), 32'd1);
        chk("glrej_flag", 32'(glitch[0]), 32'd1);
        glitch_clr[0] = 1'b1;
        step();
        glitch_clr[0] = 1'b0;
        chk("glclr_flag", 32'(glitch[0]), 32'd0);

        // Accept: 3-clk pulse with N=3 goes high at edge 5 for 3 clk.
        nrise = 0; nfall = 0; cnt = 0;
        pin_in[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 3) pin_in[0] = 1'b0;
            if (i == 5) chk("acc_e5_cpt", 32'(cpt_out[0]), 32'd1);
            if (i == 4) chk("acc_e4_cpt", 32'(cpt_out[0]), 32'd0);
            if (cpt_out[0]) cnt++;
            if (rise[0]) nrise++;
            if (fall[0]) nfall++;
        end
        chk("acc_width", 32'(cnt), 32'd3);
        chk("acc_nrise", 32'(nrise), 32'd1);
        chk("acc_nfall", 32'(nfall), 32'd1);

        // Prescaler: pre_div=3, N=2 on channel 1.
        pre_div = 8'd3; flt_len[FW +: FW] = 4'd2;
        pin_in[1] = 1'b1;
        repeat (2) step();
        cnt = 0;
        while (!cpt_out[1] && cnt < 20) begin
            step();
            cnt++;
        end
        chk("pre_delay_ok", 32'((cnt >= 5) && (cnt <= 8)), 32'd1);
        repeat (4) step();
        stayed_high = 1'b1;
        pin_in[1] = 1'b0;
        repeat (3) step();
        pin_in[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!cpt_out[1]) stayed_high = 1'b0;
        end
        chk("pre_rej_3clk", 32'(stayed_high), 32'd1);

        // Disable mid-count: N=4, two samples accumulated, then drop ena.
        pre_div = '0; flt_len[0 +: FW] = 4'd4;
        repeat (4) step();
        pin_in[0] = 1'b1;
        repeat (4) step();
        ena[0] = 1'b0;
        step();
        chk("dis_cpt", 32'(cpt_out[0]), 32'd0);
        chk("dis_fall", 32'(fall[0]), 32'd0);
        ena[0] = 1'b1;
        cnt = 0;
        while (!cpt_out[0] && cnt < 20) begin
            step();
            cnt++;
        end
        chk("reen_samples", 32'(cnt), 32'd4);

        // Set and clear of the glitch flag in the same cycle: set wins.
        repeat (3) step();
        pin_in[0] = 1'b0;
        repeat (2) step();
        pin_in[0] = 1'b1;
        glitch_clr[0] = 1'b1;
        repeat (3) step();
        chk("setclr_flag", 32'(glitch[0]), 32'd1);
        glitch_clr[0] = 1'b0;
        step();

        // Async reset mid-filter clears outputs within the same cycle.
        pin_in[1] = 1'b0;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all_zero("reset_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(5) == 0)  pin_in[k] = ~pin_in[k];
                if ($urandom_range(60) == 0) ena[k] = ~ena[k];
                if ($urandom_range(90) == 0) flt_len[k*FW +: FW] = 4'($urandom_range(6));
                glitch_clr[k] = ($urandom_range(9) == 0);
            end
            if ($urandom_range(120) == 0) pre_div = 8'($urandom_range(4));
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
